// File: rtl/bus_pkg.sv
// Shared types and index constants for the bus transfer sequencer.
// Source and destination indices select the bus-mux input and the load-enable line respectively.
package bus_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int NSRC_DEF  = 24;
  localparam int NDST_DEF  = 24;

  localparam int SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
  localparam int SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
  localparam int SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
  localparam int SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
  localparam int SRC_HI  = 16, SRC_LO  = 17, SRC_ZHI = 18, SRC_ZLO = 19;
  localparam int SRC_PC  = 20, SRC_MDR = 21, SRC_INPORT = 22, SRC_C = 23;

  localparam int DST_R0  = 0,  DST_R1  = 1,  DST_R2  = 2,  DST_R3  = 3;
  localparam int DST_R4  = 4,  DST_R5  = 5,  DST_R6  = 6,  DST_R7  = 7;
  localparam int DST_R8  = 8,  DST_R9  = 9,  DST_R10 = 10, DST_R11 = 11;
  localparam int DST_R12 = 12, DST_R13 = 13, DST_R14 = 14, DST_R15 = 15;
  localparam int DST_HI  = 16, DST_LO  = 17, DST_PC  = 18, DST_MAR = 19;
  localparam int DST_MDR = 20, DST_OUTPORT = 21, DST_Y = 22, DST_IR = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
  } xfer_req_t;

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Request handshake plus the one-hot bus enables and status seen by the control unit.
// master = control unit side, slave = sequencer side.
interface bus_transfer_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int NSRC  = 24,
  parameter int NDST  = 24
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_src;
  logic [4:0]      req_dst;
  logic [NSRC-1:0] src_out;
  logic [NDST-1:0] dst_in;
  logic            busy;
  logic            err_illegal;
  logic [CW-1:0]   fifo_count;

  modport master (
    output req_valid, req_src, req_dst,
    input  req_ready, src_out, dst_in, busy, err_illegal, fifo_count
  );

  modport slave (
    input  req_valid, req_src, req_dst,
    output req_ready, src_out, dst_in, busy, err_illegal, fifo_count
  );

endinterface

// File: rtl/bus_xfer_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO holding pending register transfers.
// Latency: pushed entry visible at pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
module bus_xfer_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          push,
  input  xfer_req_t     push_dat,
  input  logic          pop,
  output xfer_req_t     pop_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  xfer_req_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Purpose: queue register transfers, drive one-hot bus source then destination enables (bypass: BUS_XFER_BYPASS_EN).
// Latency: src_out 2 edges after accept (1 with bypass into idle/empty), dst_in one edge later; 2 cycles per transfer.
// Backpressure: req_ready drops while the request FIFO holds DEPTH entries.
module bus_transfer_sequencer
  import bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int NDST  = NDST_DEF
) (
  input  logic                     clock,
  input  logic                     clear,
  bus_transfer_sequencer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  seq_state_t      state, state_n;
  logic [NSRC-1:0] src_out_q, src_out_n;
  logic [NDST-1:0] dst_in_q, dst_in_n;
  logic [4:0]      cur_dst, cur_dst_n;
  logic            err_q;

  xfer_req_t       req_in;
  xfer_req_t       fifo_dat;
  xfer_req_t       nxt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            accept;
  logic            legal;
  logic            bypass_take;
  logic            load;

  assign req_in    = '{src: bus.req_src, dst: bus.req_dst};
  assign accept    = bus.req_valid && bus.req_ready;
  assign legal     = (int'(bus.req_src) < NSRC) && (int'(bus.req_dst) < NDST);

`ifdef BUS_XFER_BYPASS_EN
  assign bypass_take = accept && legal && (state == IDLE) && fifo_empty;
`else
  assign bypass_take = 1'b0;
`endif

  assign fifo_push = accept && legal && !bypass_take && !fifo_full;

  bus_xfer_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clock    (clock),
    .clear    (clear),
    .push     (fifo_push),
    .push_dat (req_in),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_n   = state;
    src_out_n = src_out_q;
    dst_in_n  = '0;
    cur_dst_n = cur_dst;
    nxt       = fifo_dat;
    load      = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        src_out_n = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
        end else if (bypass_take) begin
          nxt  = req_in;
          load = 1'b1;
        end
      end
      DRIVE: begin
        // Source keeps driving while the destination samples a settled bus.
        state_n  = LATCH;
        dst_in_n = NDST'(1) << cur_dst;
      end
      LATCH: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
        end else begin
          state_n   = IDLE;
          src_out_n = '0;
        end
      end
      default: begin
        state_n   = IDLE;
        src_out_n = '0;
      end
    endcase
    if (load) begin
      state_n   = DRIVE;
      src_out_n = NSRC'(1) << nxt.src;
      cur_dst_n = nxt.dst;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      src_out_q <= '0;
      dst_in_q  <= '0;
      cur_dst   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      src_out_q <= src_out_n;
      dst_in_q  <= dst_in_n;
      cur_dst   <= cur_dst_n;
      err_q     <= accept && !legal;
    end
  end

  assign bus.req_ready   = (fifo_count < CW'(DEPTH));
  assign bus.src_out     = src_out_q;
  assign bus.dst_in      = dst_in_q;
  assign bus.busy        = (state != IDLE) || !fifo_empty;
  assign bus.err_illegal = err_q;
  assign bus.fifo_count  = fifo_count;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench for bus_transfer_sequencer: scoreboard of expected transfers plus per-scenario tasks.
// Expectations follow BUS_XFER_BYPASS_EN when the build defines it.
module tb_bus_transfer_sequencer;
  import bus_pkg::*;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  bus_transfer_sequencer_if bus ();

  bus_transfer_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int        n_chk  = 0;
  int        n_fail = 0;
  int        cyc    = 0;
  logic      mon_en = 1'b0;
  xfer_req_t sb [$];
  int        pulse_q [$];
  xfer_req_t mon_e;
  logic [23:0] mon_src;
  logic [23:0] mon_dst;

  always @(posedge clock) cyc <= cyc + 1;

  // Every cycle: one-hot invariants; each destination pulse retires the oldest expected transfer.
  always @(negedge clock) begin
    if (mon_en) begin
      n_chk++;
      if (!$onehot0(bus.src_out) || !$onehot0(bus.dst_in) ||
          (bus.dst_in != '0 && bus.src_out == '0)) begin
        n_fail++;
        $display("FAIL onehot: src_out=%h dst_in=%h required one-hot0 with dst_in only under src_out",
                 bus.src_out, bus.dst_in);
      end
      if (bus.dst_in != '0) begin
        pulse_q.push_back(cyc);
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: dst_in=%h src_out=%h required no transfer", bus.dst_in, bus.src_out);
        end else begin
          mon_e   = sb.pop_front();
          mon_src = 24'(1) << mon_e.src;
          mon_dst = 24'(1) << mon_e.dst;
          if (bus.src_out !== mon_src || bus.dst_in !== mon_dst) begin
            n_fail++;
            $display("FAIL sb_xfer: src_out=%h dst_in=%h required src_out=%h dst_in=%h",
                     bus.src_out, bus.dst_in, mon_src, mon_dst);
          end
        end
      end
    end
  end

  // Called just after a negedge; returns just after the negedge following the accepting edge.
  task automatic send(input logic [4:0] s, input logic [4:0] d);
    int n;
    xfer_req_t e;
    bus.req_valid = 1'b1;
    bus.req_src   = s;
    bus.req_dst   = d;
    n = 0;
    while (!bus.req_ready && n < 64) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (n >= 64) begin
      n_fail++;
      $display("FAIL send_timeout: req_ready=%b required 1 within 64 cycles", bus.req_ready);
    end else begin
      @(posedge clock);
      if (s < 5'd24 && d < 5'd24) begin
        e.src = s;
        e.dst = d;
        sb.push_back(e);
      end
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((bus.busy || sb.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (bus.busy || sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%b pending=%0d required busy=0 pending=0", bus.busy, sb.size());
    end
  endtask

  task automatic test_reset();
    clear         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_dst   = '0;
    repeat (2) @(negedge clock);
    n_chk++;
    if (bus.src_out !== '0 || bus.dst_in !== '0) begin
      n_fail++;
      $display("FAIL reset_enables: src_out=%h dst_in=%h required 0", bus.src_out, bus.dst_in);
    end
    n_chk++;
    if (bus.busy !== 1'b0 || bus.err_illegal !== 1'b0 || bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b err=%b count=%0d required 0 0 0",
               bus.busy, bus.err_illegal, bus.fifo_count);
    end
    clear = 1'b0;
    @(negedge clock);
    n_chk++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [23:0] es;
    logic [23:0] ed;
    es = '0;
    es[SRC_PC] = 1'b1;
    ed = '0;
    ed[DST_MAR] = 1'b1;
    send(5'(SRC_PC), 5'(DST_MAR));
`ifdef BUS_XFER_BYPASS_EN
    n_chk++;
    if (bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_count: fifo_count=%0d required 0", bus.fifo_count);
    end
`else
    n_chk++;
    if (bus.fifo_count !== 3'd1 || bus.src_out !== '0) begin
      n_fail++;
      $display("FAIL single_queued: fifo_count=%0d src_out=%h required 1 and 0", bus.fifo_count, bus.src_out);
    end
    @(negedge clock);
`endif
    n_chk++;
    if (bus.src_out !== es || bus.dst_in !== '0) begin
      n_fail++;
      $display("FAIL single_drive: src_out=%h dst_in=%h required %h and 0", bus.src_out, bus.dst_in, es);
    end
    @(negedge clock);
    n_chk++;
    if (bus.src_out !== es || bus.dst_in !== ed) begin
      n_fail++;
      $display("FAIL single_latch: src_out=%h dst_in=%h required %h and %h", bus.src_out, bus.dst_in, es, ed);
    end
    @(negedge clock);
    n_chk++;
    if (bus.src_out !== '0 || bus.dst_in !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: src_out=%h dst_in=%h busy=%b required 0 0 0",
               bus.src_out, bus.dst_in, bus.busy);
    end
  endtask

  task automatic test_illegal();
    logic [4:0] s_tab [3];
    logic [4:0] d_tab [3];
    s_tab = '{5'd24, 5'd2, 5'd31};
    d_tab = '{5'd3, 5'd24, 5'd31};
    for (int i = 0; i < 3; i++) begin
      send(s_tab[i], d_tab[i]);
      n_chk++;
      if (bus.err_illegal !== 1'b1 || bus.fifo_count !== 3'd0 || bus.src_out !== '0) begin
        n_fail++;
        $display("FAIL illegal_pulse[%0d]: err=%b count=%0d src_out=%h required 1 0 0",
                 i, bus.err_illegal, bus.fifo_count, bus.src_out);
      end
      @(negedge clock);
      n_chk++;
      if (bus.err_illegal !== 1'b0 || bus.busy !== 1'b0 || bus.dst_in !== '0) begin
        n_fail++;
        $display("FAIL illegal_after[%0d]: err=%b busy=%b dst_in=%h required 0 0 0",
                 i, bus.err_illegal, bus.busy, bus.dst_in);
      end
    end
  endtask

  task automatic test_fill();
    logic [4:0] s_tab [8];
    logic [4:0] d_tab [8];
    s_tab = '{5'd1, 5'd3, 5'd20, 5'd21, 5'd22, 5'd23, 5'd0, 5'd15};
    d_tab = '{5'd2, 5'd3, 5'd19, 5'd20, 5'd23, 5'd22, 5'd16, 5'd0};
    pulse_q.delete();
    for (int i = 0; i < 8; i++) send(s_tab[i], d_tab[i]);
    n_chk++;
    if (bus.fifo_count !== 3'd4 || bus.req_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d ready=%b busy=%b required 4 0 1",
               bus.fifo_count, bus.req_ready, bus.busy);
    end
    wait_idle(100);
    n_chk++;
    if (pulse_q.size() != 8) begin
      n_fail++;
      $display("FAIL fill_pulses: got %0d required 8", pulse_q.size());
    end else begin
      for (int i = 1; i < 8; i++) begin
        n_chk++;
        if (pulse_q[i] - pulse_q[i-1] != 2) begin
          n_fail++;
          $display("FAIL fill_gap[%0d]: %0d cycles required 2", i, pulse_q[i] - pulse_q[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(5'd1, 5'd2);
    send(5'd3, 5'd4);
    send(5'd5, 5'd6);
    send(5'd7, 5'd8);
    n = 0;
    while (!(bus.dst_in != '0 && bus.fifo_count >= 3'd1) && n < 10) begin
      @(negedge clock);
      n++;
    end
    n_chk++;
    if (bus.dst_in == '0) begin
      n_fail++;
      $display("FAIL resetmid_latch: dst_in=%h count=%0d required latch with queue", bus.dst_in, bus.fifo_count);
    end
    #1;
    clear = 1'b1;
    #1;
    sb.delete();
    n_chk++;
    if (bus.src_out !== '0 || bus.dst_in !== '0 || bus.fifo_count !== 3'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL resetmid_clear: src_out=%h dst_in=%h count=%0d busy=%b required all 0",
               bus.src_out, bus.dst_in, bus.fifo_count, bus.busy);
    end
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      n_chk++;
      if (bus.src_out !== '0 || bus.dst_in !== '0 || bus.req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL resetmid_quiet[%0d]: src_out=%h dst_in=%h ready=%b required 0 0 1",
                 i, bus.src_out, bus.dst_in, bus.req_ready);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) @(negedge clock);
      send(5'($urandom_range(0, 23)), 5'($urandom_range(0, 23)));
    end
    wait_idle(200);
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_fill();
    test_reset_mid();
    test_random();
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
